selector_temperatura_agua: RTL and testbench
============================================

SELECTOR_TEMPERATURA_AGUA -- requirements
Module: selector_temperatura_agua

Interface
REQ-001 Parameter N_LEVELS, default 4: number of temperature levels; legal range 4..16; level 0 = Ambiente, levels 1..N_LEVELS-1 = hottest to coldest.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clocks required to accept a button change.
REQ-003 Parameter LONG_PRESS, default 2000000: hold clocks on the up button that force Ambiente.
REQ-004 Parameter PWM_DIV, default 1000: clocks per mixing slot.
REQ-005 Parameter MODO_CIRCULAR, default 1: 1 = wrap at ends; 0 = saturate at ends.
REQ-006 Derived LW = clog2(N_LEVELS).
REQ-007 iClk_Temperatura  in  1  single system clock, rising edge.
REQ-008 iReset_Temperatura  in  1  reset, asynchronous, active-low.
REQ-009 iBoton_Temperatura  in  1  raw up button (next level), asynchronous to clock, bouncy.
REQ-010 iBoton_Bajar  in  1  raw down button (previous level), asynchronous to clock, bouncy.
REQ-011 iHabilitar  in  1  valve enable; low = both valves off, level held.
REQ-012 iEstado_Temp  out  LW  current level, registered.
REQ-013 iAgua_Caliente  out  1  hot valve drive, registered.
REQ-014 iAgua_Fria  out  1  cold valve drive, registered.
REQ-015 iPulso_Temperatura  out  1  one-clock pulse on every level change.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debouncer; the debounced value SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive clocks; any intervening match restarts the count.
REQ-017 Level SHALL update exactly one clock after a debounced rising edge; raw-edge-to-level latency = 2 + DEBOUNCE_CYCLES + 1 clocks.
REQ-018 Up press: level+1; at N_LEVELS-1, wraps to 0 if MODO_CIRCULAR=1, otherwise holds.
REQ-019 Down press: level-1; at 0, wraps to N_LEVELS-1 if MODO_CIRCULAR=1, otherwise holds.
REQ-020 Debounced rising edges on both buttons in the same clock SHALL be ignored (no change, no pulse).
REQ-021 Hold counter SHALL count clocks while debounced up is high, saturating; on reaching LONG_PRESS, level SHALL be forced to 0 once per hold, with a pulse if the level was nonzero; release clears the counter.
REQ-022 iPulso_Temperatura SHALL be high for exactly the clock after the level register changes; saturated or ignored presses give no pulse.
REQ-023 Mixing slot counter SHALL advance every PWM_DIV clocks through 0..N_LEVELS-3, wrapping.
REQ-024 Level k>=1: iAgua_Caliente = (slot < N_LEVELS-1-k); iAgua_Fria = its complement; level 1 is hot full-time, level N_LEVELS-1 is cold full-time, and exactly one valve is on.
REQ-025 Level 0 (Ambiente): both valves SHALL be on.
REQ-026 iHabilitar low: both valves SHALL be 0 within one clock; buttons still operate; prior valve pattern SHALL resume one clock after iHabilitar returns high.
REQ-027 Valve outputs SHALL be registered one clock after level/slot; no combinational path from inputs to outputs.

Reset
REQ-028 Asserting reset SHALL immediately clear, regardless of clock: level 0, iPulso_Temperatura 0, iAgua_Caliente 0, iAgua_Fria 0, all synchronizer, debounce, hold, slot and divider state 0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard the partial count; a button held through release of reset SHALL register as a new press after the full debounce latency.
REQ-030 Valves SHALL follow REQ-025/026 from the first clock after reset deassertion.

Structure
REQ-031 Package temperatura_pkg SHALL hold the NIVEL_AMBIENTE = 0 constant and the default parameter values.
REQ-032 Synchronizer plus debouncer SHALL be one sub-module, antirrebote, instantiated once per button.

Verification (N_LEVELS=4, DEBOUNCE_CYCLES=4, LONG_PRESS=40, PWM_DIV=2)
REQ-033 Four clean up presses from reset -> level 1,2,3,0; one pulse each; each level 7 clocks after raw edge.
REQ-034 Up press glitching high 3 clocks, then low, then high -> only the final stable press counts; exactly one increment.
REQ-035 MODO_CIRCULAR=0: down at 0 and up at 3 -> level unchanged, no pulse; MODO_CIRCULAR=1: down at 0 -> level 3.
REQ-036 Level 2, hold up 60 clocks -> level 3 after 7 clocks, then 0 at hold count 40, two pulses total; level 2 -> hot/cold alternate every 2 clocks, never both on.
REQ-037 Simultaneous clean presses on both buttons -> no change; iHabilitar low at level 1 -> valves 0/0 next clock, hot restored after re-enable.
REQ-038 Reset pulsed mid-hold at level 3 -> outputs 0 immediately; held button registers as a press 7 clocks after reset release -> level 1.

Source files
------------

// File: rtl/temperatura_pkg.sv
`default_nettype none
// ============================================================================
// Module  : temperatura_pkg
// Brief   : Shared constants and default parameters for the water temperature
//           selector (Ambiente level and timing defaults).
// Rev     : 1.0 - initial release
// ============================================================================
package temperatura_pkg;

  // Level index that drives both valves open (mixed, ambient water)
  localparam int NIVEL_AMBIENTE = 0;

  // Default parameter values for selector_temperatura_agua
  localparam int DEF_N_LEVELS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_LONG_PRESS      = 2000000;
  localparam int DEF_PWM_DIV         = 1000;
  localparam int DEF_MODO_CIRCULAR   = 1;

  // Bits needed to hold any value in 0..maxVal, never less than one bit
  function automatic int anchoContador(input int maxVal);
    return (maxVal > 1) ? $clog2(maxVal + 1) : 1;
  endfunction

endpackage : temperatura_pkg
`default_nettype wire

// File: rtl/antirrebote.sv
`default_nettype none
// ============================================================================
// Module  : antirrebote
// Brief   : Two-flop synchronizer followed by a consecutive-sample debouncer
//           for one raw mechanical button.
// Rev     : 1.0 - initial release
// ============================================================================
module antirrebote
  import temperatura_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_boton,
  output logic o_estable
);

  localparam int CW = anchoContador(DEBOUNCE_CYCLES);
  // Last count value before the stable output is allowed to flip
  localparam logic [CW-1:0] c_CntFin = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_estable;
  logic [CW-1:0] r_cnt;

  // Synchronize the raw button, then accept a change only after it persists
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_estable <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_boton;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_estable) begin
        if (r_cnt == c_CntFin) begin
          r_estable <= r_sync2;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // Any sample matching the accepted value restarts the run
        r_cnt <= '0;
      end
    end
  end

  assign o_estable = r_estable;

endmodule : antirrebote
`default_nettype wire

// File: rtl/selector_temperatura_agua.sv
`default_nettype none
// ============================================================================
// Module  : selector_temperatura_agua
// Brief   : Two-button water temperature selector. Steps through N_LEVELS
//           levels, forces Ambiente on a long up press and time-mixes the
//           hot/cold valves according to the selected level.
// Rev     : 1.0 - initial release
// ============================================================================
module selector_temperatura_agua
  import temperatura_pkg::*;
#(
  parameter int N_LEVELS        = DEF_N_LEVELS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS      = DEF_LONG_PRESS,
  parameter int PWM_DIV         = DEF_PWM_DIV,
  parameter int MODO_CIRCULAR   = DEF_MODO_CIRCULAR,
  parameter int LW              = $clog2(N_LEVELS)
) (
  input  logic          iClk_Temperatura,
  input  logic          iReset_Temperatura,
  input  logic          iBoton_Temperatura,
  input  logic          iBoton_Bajar,
  input  logic          iHabilitar,
  output logic [LW-1:0] iEstado_Temp,
  output logic          iAgua_Caliente,
  output logic          iAgua_Fria,
  output logic          iPulso_Temperatura
);

  localparam int SW = anchoContador(N_LEVELS - 3);
  localparam int HW = anchoContador(LONG_PRESS);
  localparam int DW = anchoContador(PWM_DIV - 1);

  localparam logic [LW-1:0] c_NivelAmb = LW'(NIVEL_AMBIENTE);
  localparam logic [LW-1:0] c_NivelMax = LW'(N_LEVELS - 1);
  localparam logic [SW-1:0] c_SlotMax  = SW'(N_LEVELS - 3);
  localparam logic [DW-1:0] c_DivMax   = DW'(PWM_DIV - 1);
  localparam logic [HW-1:0] c_HoldMax  = HW'(LONG_PRESS);
  localparam logic [HW-1:0] c_HoldDisp = HW'(LONG_PRESS - 1);

  logic          w_debSubir;
  logic          w_debBajar;
  logic          r_debSubirPrev;
  logic          r_debBajarPrev;
  logic          w_flancoSubir;
  logic          w_flancoBajar;
  logic          w_forzarAmb;
  logic [HW-1:0] r_hold;
  logic [LW-1:0] r_nivel;
  logic [LW-1:0] w_nivelSig;
  logic          r_pulso;
  logic [DW-1:0] r_div;
  logic [SW-1:0] r_slot;
  logic          w_calSig;
  logic          w_friaSig;
  logic          r_caliente;
  logic          r_fria;

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_antirreboteSubir (
    .clk       (iClk_Temperatura),
    .rst_n     (iReset_Temperatura),
    .i_boton   (iBoton_Temperatura),
    .o_estable (w_debSubir)
  );

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_antirreboteBajar (
    .clk       (iClk_Temperatura),
    .rst_n     (iReset_Temperatura),
    .i_boton   (iBoton_Bajar),
    .o_estable (w_debBajar)
  );

  assign w_flancoSubir = w_debSubir & ~r_debSubirPrev;
  assign w_flancoBajar = w_debBajar & ~r_debBajarPrev;
  // Fires on the single clock where the hold count reaches LONG_PRESS
  assign w_forzarAmb   = w_debSubir && (r_hold == c_HoldDisp);

  // Remember the debounced buttons for edge detection and count the up hold
  always_ff @(posedge iClk_Temperatura or negedge iReset_Temperatura) begin
    if (!iReset_Temperatura) begin
      r_debSubirPrev <= 1'b0;
      r_debBajarPrev <= 1'b0;
      r_hold         <= '0;
    end else begin
      r_debSubirPrev <= w_debSubir;
      r_debBajarPrev <= w_debBajar;
      if (!w_debSubir) begin
        r_hold <= '0;
      end else if (r_hold != c_HoldMax) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  // Next level: long press wins, simultaneous edges cancel, ends wrap or hold
  always_comb begin
    w_nivelSig = r_nivel;
    if (w_forzarAmb) begin
      w_nivelSig = c_NivelAmb;
    end else if (w_flancoSubir && !w_flancoBajar) begin
      if (r_nivel == c_NivelMax) begin
        w_nivelSig = (MODO_CIRCULAR != 0) ? c_NivelAmb : r_nivel;
      end else begin
        w_nivelSig = r_nivel + 1'b1;
      end
    end else if (w_flancoBajar && !w_flancoSubir) begin
      if (r_nivel == c_NivelAmb) begin
        w_nivelSig = (MODO_CIRCULAR != 0) ? c_NivelMax : r_nivel;
      end else begin
        w_nivelSig = r_nivel - 1'b1;
      end
    end
  end

  // Level register plus a one-clock pulse whenever it actually changes
  always_ff @(posedge iClk_Temperatura or negedge iReset_Temperatura) begin
    if (!iReset_Temperatura) begin
      r_nivel <= c_NivelAmb;
      r_pulso <= 1'b0;
    end else begin
      r_nivel <= w_nivelSig;
      r_pulso <= (w_nivelSig != r_nivel);
    end
  end

  // Mixing time base: divider ticks the slot index through N_LEVELS-2 slots
  always_ff @(posedge iClk_Temperatura or negedge iReset_Temperatura) begin
    if (!iReset_Temperatura) begin
      r_div  <= '0;
      r_slot <= '0;
    end else if (r_div == c_DivMax) begin
      r_div  <= '0;
      r_slot <= (r_slot == c_SlotMax) ? '0 : r_slot + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Valve pattern: Ambiente opens both, otherwise hot for the first slots
  always_comb begin
    w_calSig  = 1'b0;
    w_friaSig = 1'b0;
    if (iHabilitar) begin
      if (r_nivel == c_NivelAmb) begin
        w_calSig  = 1'b1;
        w_friaSig = 1'b1;
      end else begin
        w_calSig  = (int'(r_slot) < (N_LEVELS - 1 - int'(r_nivel)));
        w_friaSig = ~w_calSig;
      end
    end
  end

  // Register the valve drives so outputs never see a combinational input path
  always_ff @(posedge iClk_Temperatura or negedge iReset_Temperatura) begin
    if (!iReset_Temperatura) begin
      r_caliente <= 1'b0;
      r_fria     <= 1'b0;
    end else begin
      r_caliente <= w_calSig;
      r_fria     <= w_friaSig;
    end
  end

  assign iEstado_Temp       = r_nivel;
  assign iAgua_Caliente     = r_caliente;
  assign iAgua_Fria         = r_fria;
  assign iPulso_Temperatura = r_pulso;

endmodule : selector_temperatura_agua
`default_nettype wire

// File: tb/tb_selector_temperatura_agua.sv
`default_nettype none
// ============================================================================
// Module  : tb_selector_temperatura_agua
// Brief   : Self-checking bench; a saturating and a circular instance share
//           the same button/enable stimulus and are compared every clock
//           against a behavioural model of the selector rules.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_selector_temperatura_agua;

  localparam int NL  = 4;
  localparam int DB  = 4;
  localparam int LP  = 40;
  localparam int PWM = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       bUp = 1'b0;
  logic       bDn = 1'b0;
  logic       hab = 1'b1;
  logic [1:0] nivelS, nivelC;
  logic       calS, friaS, pulsoS;
  logic       calC, friaC, pulsoC;

  int nTests = 0;
  int nFallos = 0;

  always #5 clk = ~clk;

  selector_temperatura_agua #(
    .N_LEVELS(NL), .DEBOUNCE_CYCLES(DB), .LONG_PRESS(LP),
    .PWM_DIV(PWM), .MODO_CIRCULAR(0)
  ) dutS (
    .iClk_Temperatura   (clk),
    .iReset_Temperatura (rst_n),
    .iBoton_Temperatura (bUp),
    .iBoton_Bajar       (bDn),
    .iHabilitar         (hab),
    .iEstado_Temp       (nivelS),
    .iAgua_Caliente     (calS),
    .iAgua_Fria         (friaS),
    .iPulso_Temperatura (pulsoS)
  );

  selector_temperatura_agua #(
    .N_LEVELS(NL), .DEBOUNCE_CYCLES(DB), .LONG_PRESS(LP),
    .PWM_DIV(PWM), .MODO_CIRCULAR(1)
  ) dutC (
    .iClk_Temperatura   (clk),
    .iReset_Temperatura (rst_n),
    .iBoton_Temperatura (bUp),
    .iBoton_Bajar       (bDn),
    .iHabilitar         (hab),
    .iEstado_Temp       (nivelC),
    .iAgua_Caliente     (calC),
    .iAgua_Fria         (friaC),
    .iPulso_Temperatura (pulsoC)
  );

  // ---------------- behavioural model (index 0 = saturating, 1 = circular)
  int mN;
  int mNivel[2];
  int mPulso[2];
  int mCal[2];
  int mFria[2];
  bit mDebUp, mDebDn, mRoseUp, mRoseDn;
  int mHold;
  bit qUp[$];
  bit qDn[$];

  task automatic comprobar(input string etiqueta, input int obs, input int esp);
    nTests++;
    if (obs != esp) begin
      nFallos++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", etiqueta, obs, esp, $time);
    end
  endtask

  task automatic modeloReset();
    mN = 0;
    for (int m = 0; m < 2; m++) begin
      mNivel[m] = 0; mPulso[m] = 0; mCal[m] = 0; mFria[m] = 0;
    end
    mDebUp = 0; mDebDn = 0; mRoseUp = 0; mRoseDn = 0; mHold = 0;
    qUp.delete(); qDn.delete();
    for (int k = 0; k < DB + 2; k++) begin
      qUp.push_back(1'b0);
      qDn.push_back(1'b0);
    end
  endtask

  // Debounced value flips once the samples taken 2..DB+1 clocks ago all disagree
  function automatic bit cambia(input bit q[$], input bit actual);
    for (int k = 2; k < DB + 2; k++)
      if (q[k] == actual) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modeloFlanco();
    bit subir, bajar, forzar;
    int slotPrev, viejo, nuevo;
    subir    = mRoseUp;
    bajar    = mRoseDn;
    forzar   = mDebUp && (mHold + 1 == LP);
    slotPrev = (mN / PWM) % (NL - 2);
    mN++;
    if (mDebUp) begin
      if (mHold < LP) mHold++;
    end else begin
      mHold = 0;
    end
    for (int m = 0; m < 2; m++) begin
      viejo = mNivel[m];
      nuevo = viejo;
      if (!hab) begin
        mCal[m] = 0; mFria[m] = 0;
      end else if (viejo == 0) begin
        mCal[m] = 1; mFria[m] = 1;
      end else begin
        mCal[m]  = (slotPrev < NL - 1 - viejo) ? 1 : 0;
        mFria[m] = 1 - mCal[m];
      end
      if (forzar) nuevo = 0;
      else if (subir && !bajar) nuevo = (viejo == NL - 1) ? ((m == 1) ? 0 : viejo) : viejo + 1;
      else if (bajar && !subir) nuevo = (viejo == 0) ? ((m == 1) ? NL - 1 : viejo) : viejo - 1;
      mPulso[m] = (nuevo != viejo) ? 1 : 0;
      mNivel[m] = nuevo;
    end
    qUp.push_front(bUp); void'(qUp.pop_back());
    qDn.push_front(bDn); void'(qDn.pop_back());
    mRoseUp = 0;
    mRoseDn = 0;
    if (cambia(qUp, mDebUp)) begin mDebUp = !mDebUp; mRoseUp = mDebUp; end
    if (cambia(qDn, mDebDn)) begin mDebDn = !mDebDn; mRoseDn = mDebDn; end
  endtask

  task automatic comprobarTodo();
    comprobar("nivelS", int'(nivelS), mNivel[0]);
    comprobar("pulsoS", int'(pulsoS), mPulso[0]);
    comprobar("calS",   int'(calS),   mCal[0]);
    comprobar("friaS",  int'(friaS),  mFria[0]);
    comprobar("nivelC", int'(nivelC), mNivel[1]);
    comprobar("pulsoC", int'(pulsoC), mPulso[1]);
    comprobar("calC",   int'(calC),   mCal[1]);
    comprobar("friaC",  int'(friaC),  mFria[1]);
  endtask

  task automatic paso();
    @(posedge clk);
    modeloFlanco();
    #1;
    comprobarTodo();
  endtask

  // Assert reset away from the edge, check the immediate clear, release on negedge
  task automatic aplicarReset();
    rst_n = 1'b0;
    #1;
    modeloReset();
    comprobar("rstNivelS", int'(nivelS), 0);
    comprobar("rstPulsoS", int'(pulsoS), 0);
    comprobar("rstCalS",   int'(calS),   0);
    comprobar("rstFriaS",  int'(friaS),  0);
    comprobar("rstNivelC", int'(nivelC), 0);
    comprobar("rstPulsoC", int'(pulsoC), 0);
    comprobar("rstCalC",   int'(calC),   0);
    comprobar("rstFriaC",  int'(friaC),  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulsar(input bit up, input bit dn, input int alto, input int bajo);
    bUp = up; bDn = dn;
    repeat (alto) paso();
    bUp = 1'b0; bDn = 1'b0;
    repeat (bajo) paso();
  endtask

  initial begin
    int len;
    modeloReset();
    #3;
    aplicarReset();

    // Four clean up presses: 1, 2, 3, then 0 (wrap) / hold at 3 (saturating)
    for (int i = 0; i < 4; i++) pulsar(1'b1, 1'b0, 10, 10);

    // Glitchy press: short high burst, low, then a stable press
    bUp = 1'b1; repeat (3) paso();
    bUp = 1'b0; repeat (2) paso();
    pulsar(1'b1, 1'b0, 10, 10);

    // Down presses around the low end
    pulsar(1'b0, 1'b1, 10, 10);
    pulsar(1'b0, 1'b1, 10, 10);
    pulsar(1'b0, 1'b1, 10, 10);

    // Long hold from the current level forces Ambiente
    pulsar(1'b1, 1'b0, 60, 12);

    // Step to level 2 and watch the hot/cold alternation
    pulsar(1'b1, 1'b0, 10, 10);
    pulsar(1'b1, 1'b0, 10, 20);

    // Simultaneous presses are ignored
    pulsar(1'b1, 1'b1, 10, 10);

    // Disable and re-enable the valves
    hab = 1'b0; repeat (5) paso();
    hab = 1'b1; repeat (5) paso();

    // Randomized button and enable activity
    for (int s = 0; s < 60; s++) begin
      bUp = 1'($urandom_range(0, 1));
      bDn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) hab = ~hab;
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 9) == 0) len = 45;
      repeat (len) paso();
    end
    hab = 1'b1;
    pulsar(1'b0, 1'b0, 0, 12);

    // Reach level 3, then reset mid-hold with the up button still pressed
    modeloReset();
    aplicarReset();
    pulsar(1'b1, 1'b0, 10, 10);
    pulsar(1'b1, 1'b0, 10, 10);
    bUp = 1'b1; repeat (20) paso();
    aplicarReset();
    repeat (15) paso();
    bUp = 1'b0; repeat (10) paso();

    $display("[TB] %0d tests run, %0d failed", nTests, nFallos);
    $finish;
  end

endmodule : tb_selector_temperatura_agua
`default_nettype wire
